// File: rtl/seq_mon_pkg.sv
// Shared types and defaults for the sequence phase monitor.
package seq_mon_pkg;

  localparam int unsigned DefW  = 4;
  localparam int unsigned DefRw = 4;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/sequence_phase_monitor_if.sv
// Bus between a one-hot phase generator (master) and the phase monitor (slave).
interface sequence_phase_monitor_if #(
  parameter int unsigned w  = 4,
  parameter int unsigned rw = 4
);

  logic                 start;
  logic [w-1:0]         secv;
  logic [rw-1:0]        rounds;
  logic [$clog2(w)-1:0] phase;
  logic                 phase_valid;
  logic [rw-1:0]        rounds_done;
  logic                 finish;
  logic                 seq_error;

  modport master (
    output start, secv, rounds,
    input  phase, phase_valid, rounds_done, finish, seq_error
  );

  modport slave (
    input  start, secv, rounds,
    output phase, phase_valid, rounds_done, finish, seq_error
  );

endinterface

// File: rtl/sequence_phase_monitor_onehot_enc.sv
// One-hot to binary encoder; onehot_ok_o flags exactly one bit set.
module onehot_enc #(
  parameter int unsigned w = 4
) (
  input  logic [w-1:0]         vec_i,
  output logic [$clog2(w)-1:0] idx_o,
  output logic                 onehot_ok_o
);

  localparam int unsigned PW = $clog2(w);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < w; i++) begin
      if (vec_i[i]) idx_o = idx_o | PW'(i);
    end
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    onehot_ok_o = (vec_i != '0) && ((vec_i & (vec_i - 1'b1)) == '0);
  end

endmodule

// File: rtl/sequence_phase_monitor.sv
// Checks a one-hot phase sequence, counts rounds and pulses finish.
// Define SEQ_MON_STRICT_EN to make a repeated (held) phase a protocol error.
module sequence_phase_monitor
  import seq_mon_pkg::*;
#(
  parameter int unsigned w  = DefW,
  parameter int unsigned rw = DefRw
) (
  input logic                    clk,
  input logic                    rst,
  sequence_phase_monitor_if.slave bus
);

  localparam int unsigned PW = $clog2(w);
  localparam logic [PW-1:0] LastPhase = PW'(w - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          phase_valid_q, phase_valid_d;
  logic [rw-1:0] rounds_done_q, rounds_done_d;
  logic [rw-1:0] target_q, target_d;
  logic          finish_q, finish_d;
  logic          seq_error_q, seq_error_d;
  logic          first_q, first_d;

  logic [PW-1:0] idx;
  logic          onehot_ok;
  logic [PW-1:0] next_phase;
  logic          is_advance, legal, wrap, round_end;

  onehot_enc #(.w(w)) u_enc (
    .vec_i       (bus.secv),
    .idx_o       (idx),
    .onehot_ok_o (onehot_ok)
  );

  always_comb begin
    next_phase = (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
    is_advance = first_q ? (idx == '0) : (idx == next_phase);
`ifdef SEQ_MON_STRICT_EN
    legal      = onehot_ok && is_advance;
`else
    legal      = onehot_ok && (is_advance || (!first_q && idx == phase_q));
`endif
    wrap       = !first_q && is_advance && (phase_q == LastPhase);
    round_end  = (idx == LastPhase) && ((rounds_done_q + 1'b1) == target_q);
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    rounds_done_d = rounds_done_q;
    target_d      = target_q;
    finish_d      = 1'b0;
    seq_error_d   = seq_error_q;
    first_d       = first_q;

    if (bus.start) begin
      // A start in any state re-arms and outranks the same-cycle sample.
      state_d       = StTrack;
      phase_d       = '0;
      phase_valid_d = 1'b0;
      rounds_done_d = '0;
      target_d      = (bus.rounds == '0) ? rw'(1) : bus.rounds;
      seq_error_d   = 1'b0;
      first_d       = 1'b1;
    end else begin
      unique case (state_q)
        StTrack: begin
          if (legal) begin
            phase_d       = idx;
            phase_valid_d = 1'b1;
            first_d       = 1'b0;
            if (wrap) rounds_done_d = rounds_done_q + 1'b1;
            if (round_end) begin
              finish_d      = 1'b1;
              rounds_done_d = rounds_done_q + 1'b1;
              state_d       = StDone;
            end
          end else begin
            seq_error_d   = 1'b1;
            phase_valid_d = 1'b0;
            state_d       = StErr;
          end
        end
        StIdle, StDone, StErr: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      rounds_done_q <= '0;
      target_q      <= rw'(1);
      finish_q      <= 1'b0;
      seq_error_q   <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      rounds_done_q <= rounds_done_d;
      target_q      <= target_d;
      finish_q      <= finish_d;
      seq_error_q   <= seq_error_d;
      first_q       <= first_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.rounds_done = rounds_done_q;
  assign bus.finish      = finish_q;
  assign bus.seq_error   = seq_error_q;

endmodule

// File: tb/tb_sequence_phase_monitor.sv
// Self-checking bench for sequence_phase_monitor against a run-history reference model.
module tb_sequence_phase_monitor;

  localparam int W  = 4;
  localparam int RW = 4;
`ifdef SEQ_MON_STRICT_EN
  localparam bit Strict = 1'b1;
`else
  localparam bit Strict = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sequence_phase_monitor_if #(.w(W), .rw(RW)) bus ();

  sequence_phase_monitor #(.w(W), .rw(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: mode 0 idle, 1 tracking, 2 done, 3 error.
  int         m_mode = 0;
  int         m_hist[$];
  int         m_completed = 0;
  int         m_target = 1;
  logic [1:0] e_phase = '0;
  bit         e_valid = 0, e_fin = 0, e_err = 0;

  function automatic logic [8:0] obs();
    return {bus.phase, bus.phase_valid, bus.rounds_done, bus.finish, bus.seq_error};
  endfunction

  function automatic logic [8:0] expv();
    return {e_phase, e_valid, 4'(m_completed % 16), e_fin, e_err};
  endfunction

  task automatic model_step();
    int p = 0;
    int last = 0;
    bit ok;
    e_fin = 0;
    if (rst) begin
      m_mode = 0; m_hist.delete(); m_completed = 0;
      e_phase = 0; e_valid = 0; e_err = 0;
    end else if (bus.start) begin
      m_mode = 1; m_hist.delete(); m_completed = 0;
      m_target = (bus.rounds == 0) ? 1 : int'(bus.rounds);
      e_phase = 0; e_valid = 0; e_err = 0;
    end else if (m_mode == 1) begin
      ok = ($countones(bus.secv) == 1);
      for (int i = 0; i < W; i++) if (bus.secv[i]) p = i;
      if (m_hist.size() == 0) ok = ok && (p == 0);
      else begin
        last = m_hist[$];
        ok = ok && ((p == (last + 1) % W) || (!Strict && p == last));
      end
      if (ok) begin
        if (m_hist.size() > 0 && last == W - 1 && p == 0) m_completed++;
        m_hist.push_back(p);
        e_phase = 2'(p);
        e_valid = 1;
        if (p == W - 1 && (m_completed + 1) % 16 == m_target % 16) begin
          e_fin = 1; m_completed++; m_mode = 2;
        end
      end else begin
        e_err = 1; e_valid = 0; m_mode = 3;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit s, input logic [3:0] v, input logic [3:0] r);
    bus.start = s; bus.secv = v; bus.rounds = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'b0001, 4'd3);
    repeat (2) begin
      tick();
      n_checks++;
      if (obs() !== 9'd0) begin
        n_fails++; $display("FAIL reset: got %b want %b", obs(), 9'd0);
      end
    end
    rst = 1'b0;
    drive(1'b0, 4'b0001, 4'd0);
    tick();
    n_checks++;
    if (obs() !== expv()) begin
      n_fails++; $display("FAIL idle_quiet: got %b want %b", obs(), expv());
    end
  endtask

  task automatic test_two_rounds();
    logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0001, 4'b0010, 4'b0100, 4'b1000};
    drive(1'b1, 4'b0000, 4'd2);
    tick();
    foreach (seq[i]) begin
      drive(1'b0, seq[i], 4'd2);
      tick();
      n_checks++;
      if (obs() !== expv()) begin
        n_fails++; $display("FAIL two_rounds[%0d]: got %b want %b", i, obs(), expv());
      end
      if (i == 7) begin
        n_checks++;
        if (bus.finish !== 1'b1 || bus.rounds_done !== 4'd2 || bus.phase !== 2'd3) begin
          n_fails++;
          $display("FAIL two_rounds_finish: got fin=%b rd=%0d ph=%0d want fin=1 rd=2 ph=3",
                   bus.finish, bus.rounds_done, bus.phase);
        end
      end
    end
    drive(1'b0, 4'b0000, 4'd2);
    repeat (2) begin
      tick();
      n_checks++;
      if (obs() !== {2'd3, 1'b1, 4'd2, 1'b0, 1'b0}) begin
        n_fails++; $display("FAIL done_hold: got %b want %b", obs(), {2'd3, 1'b1, 4'd2, 2'b00});
      end
    end
  endtask

  task automatic test_rounds_zero();
    drive(1'b1, 4'b0000, 4'd0);
    tick();
    for (int i = 0; i < W; i++) begin
      drive(1'b0, 4'(1 << i), 4'd5);
      tick();
      n_checks++;
      if (obs() !== expv()) begin
        n_fails++; $display("FAIL rounds_zero[%0d]: got %b want %b", i, obs(), expv());
      end
    end
    n_checks++;
    if (bus.finish !== 1'b1 || bus.rounds_done !== 4'd1) begin
      n_fails++;
      $display("FAIL rounds_zero_finish: got fin=%b rd=%0d want fin=1 rd=1",
               bus.finish, bus.rounds_done);
    end
  endtask

  task automatic test_skip_error();
    drive(1'b1, 4'b0000, 4'd2); tick();
    drive(1'b0, 4'b0001, 4'd2); tick();
    drive(1'b0, 4'b0100, 4'd2); tick();
    n_checks++;
    if (bus.seq_error !== 1'b1 || bus.finish !== 1'b0 || bus.phase_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL skip_error: got err=%b fin=%b pv=%b want err=1 fin=0 pv=0",
               bus.seq_error, bus.finish, bus.phase_valid);
    end
    drive(1'b0, 4'b0001, 4'd2); tick();
    n_checks++;
    if (obs() !== expv()) begin
      n_fails++; $display("FAIL err_hold: got %b want %b", obs(), expv());
    end
    drive(1'b1, 4'b0000, 4'd2); tick();
    n_checks++;
    if (bus.seq_error !== 1'b0) begin
      n_fails++; $display("FAIL err_clear: got err=%b want err=0", bus.seq_error);
    end
    drive(1'b0, 4'b0001, 4'd2); tick();
    n_checks++;
    if (bus.phase_valid !== 1'b1 || bus.phase !== 2'd0 || bus.seq_error !== 1'b0) begin
      n_fails++;
      $display("FAIL resume: got pv=%b ph=%0d err=%b want pv=1 ph=0 err=0",
               bus.phase_valid, bus.phase, bus.seq_error);
    end
  endtask

  task automatic test_bad_vectors();
    logic [3:0] bad [3] = '{4'b0011, 4'b0000, 4'b0001};
    foreach (bad[i]) begin
      drive(1'b1, 4'b0000, 4'd3); tick();
      drive(1'b0, 4'b0001, 4'd3); tick();
      drive(1'b0, bad[i], 4'd3);  tick();
      n_checks++;
      if (obs() !== expv()) begin
        n_fails++; $display("FAIL bad_vec[%0d]: got %b want %b", i, obs(), expv());
      end
    end
    // A first sample other than phase 0 is illegal.
    drive(1'b1, 4'b0000, 4'd3); tick();
    drive(1'b0, 4'b0010, 4'd3); tick();
    n_checks++;
    if (bus.seq_error !== 1'b1) begin
      n_fails++; $display("FAIL wrong_first: got err=%b want err=1", bus.seq_error);
    end
  endtask

  task automatic test_reset_midrun();
    logic [3:0] seq [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    drive(1'b1, 4'b0000, 4'd3); tick();
    foreach (seq[i]) begin
      drive(1'b0, seq[i], 4'd3); tick();
    end
    n_checks++;
    if (obs() !== expv()) begin
      n_fails++; $display("FAIL pre_reset: got %b want %b", obs(), expv());
    end
    rst = 1'b1;
    drive(1'b1, 4'b1000, 4'd3); tick();
    n_checks++;
    if (obs() !== 9'd0) begin
      n_fails++; $display("FAIL reset_midrun: got %b want %b", obs(), 9'd0);
    end
    rst = 1'b0;
    drive(1'b0, 4'b0001, 4'd3); tick();
    n_checks++;
    if (obs() !== 9'd0) begin
      n_fails++; $display("FAIL reset_ignores_start: got %b want %b", obs(), 9'd0);
    end
  endtask

  task automatic test_restart();
    drive(1'b1, 4'b0000, 4'd1); tick();
    drive(1'b0, 4'b0001, 4'd1); tick();
    drive(1'b0, 4'b0010, 4'd1); tick();
    drive(1'b0, 4'b0100, 4'd1); tick();
    drive(1'b1, 4'b1000, 4'd1); tick();
    n_checks++;
    if (bus.finish !== 1'b0 || obs() !== expv()) begin
      n_fails++; $display("FAIL restart_edge: got %b want %b", obs(), expv());
    end
    drive(1'b0, 4'b0001, 4'd1); tick();
    n_checks++;
    if (bus.phase !== 2'd0 || bus.phase_valid !== 1'b1 || bus.rounds_done !== 4'd0 ||
        bus.finish !== 1'b0 || bus.seq_error !== 1'b0) begin
      n_fails++; $display("FAIL restart_resume: got %b want %b", obs(), {2'd0, 1'b1, 6'd0});
    end
  endtask

  task automatic test_random();
    int r, last;
    logic [3:0] v;
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 99));
      last = (m_hist.size() > 0) ? m_hist[$] : W - 1;
      rst = (r < 2);
      if (r < 6) begin
        drive(1'b1, 4'($urandom), 4'($urandom_range(0, 3)));
      end else if (r < 10 || m_mode != 1) begin
        drive(1'b0, 4'($urandom), 4'($urandom));
      end else if (r < 20) begin
        v = 4'(1 << last);
        drive(1'b0, v, 4'($urandom));
      end else begin
        v = 4'(1 << ((last + 1) % W));
        drive(1'b0, v, 4'($urandom));
      end
      tick();
      n_checks++;
      if (obs() !== expv() || (bus.finish && bus.seq_error)) begin
        n_fails++; $display("FAIL random[%0d]: got %b want %b", c, obs(), expv());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'b0000, 4'd0);
    test_reset();
    test_two_rounds();
    test_rounds_zero();
    test_skip_error();
    test_bad_vectors();
    test_reset_midrun();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
